// File: rtl/fetch_decode_pkg.sv
// Shared constants for the fetch/decode front end: FSM encodings, field layout,
// instruction types. FETCH_PC_INC_EN (optional) makes pc_next = latched pc + 1.
package fetch_decode_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 8;
  localparam int OPND_W   = 6;
  localparam int TYPE_MSB = 7;
  localparam int TYPE_LSB = 6;
  localparam int OPND_MSB = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DEC  = 2'd3;

  typedef enum logic [1:0] {
    TYPE_LOAD  = 2'b00,
    TYPE_STORE = 2'b01,
    TYPE_ALU   = 2'b10,
    TYPE_JUMP  = 2'b11
  } inst_type_e;

endpackage

// File: rtl/inst_decoder.sv
// Combinational field split of one 8-bit instruction; the top registers these.
module inst_decoder
  import fetch_decode_pkg::*;
(
  input  logic [DATA_W-1:0] i_inst,
  output logic [1:0]        o_type,
  output logic [OPND_W-1:0] o_addr,
  output logic              o_srcdst
);

  assign o_type   = i_inst[TYPE_MSB:TYPE_LSB];
  assign o_addr   = i_inst[OPND_MSB:0];
  // Only a STORE writes memory; LOAD/ALU/JUMP treat memory as source or not at all.
  assign o_srcdst = (i_inst[TYPE_MSB:TYPE_LSB] == TYPE_STORE);

endmodule

// File: rtl/fetch_decode_unit.sv
// Four-state fetch/decode front end: IDLE -> ADDR -> DATA -> DEC -> IDLE.
// `define FETCH_PC_INC_EN to make pc_next the latched pc plus one (mod 256).
module fetch_decode_unit
  import fetch_decode_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fetch_en,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_data_in,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_inst_out,
  output logic              o_fetch_ready,
  output logic [ADDR_W-1:0] o_pc_next,
  output logic [1:0]        o_inst_type,
  output logic [OPND_W-1:0] o_dec_addr,
  output logic              o_srcdst,
  output logic              o_decode_ready,
  output logic              o_busy
);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_pc_next;
  logic [1:0]        r_type;
  logic [OPND_W-1:0] r_dec_addr;
  logic              r_srcdst;
  logic              r_fetch_ready;
  logic              r_decode_ready;

  logic [1:0]        w_type;
  logic [OPND_W-1:0] w_dec_addr;
  logic              w_srcdst;
  logic [ADDR_W-1:0] w_pc_next;

  inst_decoder u_dec (
    .i_inst   (r_inst),
    .o_type   (w_type),
    .o_addr   (w_dec_addr),
    .o_srcdst (w_srcdst)
  );

`ifdef FETCH_PC_INC_EN
  assign w_pc_next = r_pc + 8'd1;
`else
  assign w_pc_next = r_pc;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_pc           <= '0;
      r_addr         <= '0;
      r_inst         <= '0;
      r_pc_next      <= '0;
      r_type         <= '0;
      r_dec_addr     <= '0;
      r_srcdst       <= 1'b0;
      r_fetch_ready  <= 1'b0;
      r_decode_ready <= 1'b0;
    end else begin
      r_fetch_ready  <= 1'b0;
      r_decode_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // pc is captured here so later pc motion cannot disturb this fetch
          if (i_fetch_en) begin
            r_pc    <= i_pc;
            r_addr  <= i_pc;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: r_state <= ST_DATA;
        ST_DATA: begin
          r_inst        <= i_data_in;
          r_pc_next     <= w_pc_next;
          r_fetch_ready <= 1'b1;
          r_state       <= ST_DEC;
        end
        ST_DEC: begin
          r_type         <= w_type;
          r_dec_addr     <= w_dec_addr;
          r_srcdst       <= w_srcdst;
          r_decode_ready <= 1'b1;
          r_state        <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_addr         = r_addr;
  assign o_inst_out     = r_inst;
  assign o_fetch_ready  = r_fetch_ready;
  assign o_pc_next      = r_pc_next;
  assign o_inst_type    = r_type;
  assign o_dec_addr     = r_dec_addr;
  assign o_srcdst       = r_srcdst;
  assign o_decode_ready = r_decode_ready;
  assign o_busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Scoreboard bench for fetch_decode_unit with a one-cycle-latency memory model.
module tb_fetch_decode_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_en;
  logic [7:0] pc;
  logic [7:0] data_in = 8'h00;
  logic [7:0] addr, inst_out, pc_next;
  logic       fetch_ready, decode_ready, srcdst, busy;
  logic [1:0] inst_type;
  logic [5:0] dec_addr;

  fetch_decode_unit dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_fetch_en     (fetch_en),
    .i_pc           (pc),
    .i_data_in      (data_in),
    .o_addr         (addr),
    .o_inst_out     (inst_out),
    .o_fetch_ready  (fetch_ready),
    .o_pc_next      (pc_next),
    .o_inst_type    (inst_type),
    .o_dec_addr     (dec_addr),
    .o_srcdst       (srcdst),
    .o_decode_ready (decode_ready),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) data_in <= mem[addr];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] pc;
    logic [7:0] inst;
  } exp_t;
  exp_t fq[$];
  exp_t dq[$];
  int   fr_hist[$];
  int   dr_hist[$];
  int   last_fr = 0;
  int   last_dr = 0;

  function automatic logic [7:0] exp_pcn(input logic [7:0] p);
`ifdef FETCH_PC_INC_EN
    return p + 8'd1;
`else
    return p;
`endif
  endfunction

  // Monitor: pops the scoreboard on each ready pulse.
  always @(negedge clk) begin
    exp_t e;
    if (fetch_ready) begin
      last_fr = cyc;
      fr_hist.push_back(cyc);
      if (fq.size() == 0) chk("fr_unexpected", 1, 0);
      else begin
        e = fq.pop_front();
        chk("inst_out", inst_out, e.inst);
        chk("pc_next", pc_next, exp_pcn(e.pc));
      end
    end
    if (decode_ready) begin
      last_dr = cyc;
      dr_hist.push_back(cyc);
      if (dq.size() == 0) chk("dr_unexpected", 1, 0);
      else begin
        e = dq.pop_front();
        chk("inst_type", inst_type, e.inst[7:6]);
        chk("dec_addr", dec_addr, e.inst[5:0]);
        chk("srcdst", srcdst, (e.inst[7:6] == 2'b01));
      end
    end
  end

  task automatic push_exp(input logic [7:0] p);
    exp_t e;
    e.pc = p;
    e.inst = mem[p];
    fq.push_back(e);
    dq.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_inst"}, inst_out, 0);
    chk({tag, "_pcn"}, pc_next, 0);
    chk({tag, "_type"}, inst_type, 0);
    chk({tag, "_daddr"}, dec_addr, 0);
    chk({tag, "_sd"}, srcdst, 0);
    chk({tag, "_fr"}, fetch_ready, 0);
    chk({tag, "_dr"}, decode_ready, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while ((busy || fq.size() != 0 || dq.size() != 0) && n < 12);
    if (n >= 12) chk("timeout", 0, 1);
  endtask

  // One fetch; pc and fetch_en are disturbed right after acceptance.
  task automatic do_fetch(input logic [7:0] p);
    int acc;
    @(negedge clk);
    fetch_en = 1'b1;
    pc = p;
    push_exp(p);
    @(posedge clk); #1 acc = cyc;
    @(negedge clk);
    chk("addr_e0", addr, p);
    chk("busy_e0", busy, 1);
    fetch_en = 1'b0;
    pc = ~p;
    wait_done();
    chk("fr_lat", last_fr - acc, 2);
    chk("dr_lat", last_dr - acc, 3);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    mem[8'h05] = 8'h4A;
    mem[8'hFF] = 8'hC3;
    mem[8'h10] = 8'h9E;
    mem[8'h11] = 8'h27;
    mem[8'h20] = 8'h15;
    mem[8'h33] = 8'hEE;

    rst = 1'b1; fetch_en = 1'b0; pc = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_addr", addr, 0);

    // Single fetch of a STORE
    do_fetch(8'h05);
    chk("hold_inst", inst_out, 8'h4A);
    chk("hold_type", inst_type, 2'b01);
    chk("hold_daddr", dec_addr, 6'h0A);
    chk("hold_sd", srcdst, 1);

    // PC wrap with a JUMP
    do_fetch(8'hFF);
    chk("wrap_type", inst_type, 2'b11);
    chk("wrap_daddr", dec_addr, 6'h03);
    chk("wrap_sd", srcdst, 0);
`ifdef FETCH_PC_INC_EN
    chk("wrap_pcn", pc_next, 8'h00);
`else
    chk("wrap_pcn", pc_next, 8'hFF);
`endif

    // Back-to-back with fetch_en held high
    fr_hist.delete(); dr_hist.delete();
    @(negedge clk);
    fetch_en = 1'b1; pc = 8'h10;
    push_exp(8'h10);
    push_exp(8'h11);
    @(negedge clk);
    pc = 8'h11;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("b2b_addr2", addr, 8'h11);
    fetch_en = 1'b0;
    wait_done();
    chk("b2b_nfr", fr_hist.size(), 2);
    chk("b2b_ndr", dr_hist.size(), 2);
    if (fr_hist.size() == 2) chk("b2b_fr_gap", fr_hist[1] - fr_hist[0], 4);
    if (dr_hist.size() == 2) chk("b2b_dr_gap", dr_hist[1] - dr_hist[0], 4);

    // Mid-fetch pc change and fetch_en drop while in ADDR
    @(negedge clk);
    fetch_en = 1'b1; pc = 8'h20;
    push_exp(8'h20);
    @(negedge clk);
    pc = 8'h33; fetch_en = 1'b0;
    @(negedge clk);
    chk("mid_addr", addr, 8'h20);
    wait_done();
    chk("mid_inst", inst_out, 8'h15);

    // Reset while in DATA aborts the fetch silently
    fr_hist.delete(); dr_hist.delete();
    @(negedge clk);
    fetch_en = 1'b1; pc = 8'h33;
    @(negedge clk);
    fetch_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("rdata");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rdata_nfr", fr_hist.size(), 0);
    chk("rdata_ndr", dr_hist.size(), 0);
    do_fetch(8'h33);
    chk("after_rst_inst", inst_out, 8'hEE);

    // Reset wins over a simultaneous fetch_en
    @(negedge clk);
    rst = 1'b1; fetch_en = 1'b1; pc = 8'h44;
    @(negedge clk);
    chk("rwin_busy", busy, 0);
    chk("rwin_addr", addr, 0);
    rst = 1'b0; fetch_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("rwin_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
